// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding APB master that turns host commands into
// APB transfers. A per-transfer timeout keeps a stalled slave from hanging the
// host.
module apb_cmd_master #(
    parameter int unsigned TIMEOUT = 16'hFFFF
) (
    input  logic        i_Pclk,
    input  logic        i_Reset,
    input  logic        i_Cmd_Valid,
    output logic        o_Cmd_Ready,
    input  logic        i_Cmd_Write,
    input  logic [31:0] i_Cmd_Addr,
    input  logic [7:0]  i_Cmd_Wdata,
    output logic        o_Rsp_Valid,
    input  logic        i_Rsp_Ready,
    output logic [7:0]  o_Rsp_Rdata,
    output logic        o_Rsp_Timeout,
    output logic [31:0] o_Paddr,
    output logic        o_Psel,
    output logic        o_Penable,
    output logic        o_Pwrite,
    output logic [7:0]  o_Pwdata,
    input  logic        i_Pready,
    input  logic [7:0]  i_Prdata
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 8;

    // Timeout fires on the ACCESS edge where the counter holds TIMEOUT-1.
    localparam bit               TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_tmo_q, rsp_tmo_d;

    // Host may issue a command only when idle and not held in reset.
    assign o_Cmd_Ready = (state_q == ST_IDLE) & ~i_Reset;

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        paddr_d     = paddr_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_tmo_d   = rsp_tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (i_Cmd_Valid && o_Cmd_Ready) begin
                    paddr_d   = i_Cmd_Addr;
                    pwrite_d  = i_Cmd_Write;
                    pwdata_d  = i_Cmd_Write ? i_Cmd_Wdata : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (i_Pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : i_Prdata;
                    rsp_tmo_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_tmo_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (i_Rsp_Ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_Pclk) begin
        if (i_Reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            paddr_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            paddr_q     <= paddr_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_tmo_q   <= rsp_tmo_d;
        end
    end

    assign o_Paddr       = paddr_q;
    assign o_Psel        = psel_q;
    assign o_Penable     = penable_q;
    assign o_Pwrite      = pwrite_q;
    assign o_Pwdata      = pwdata_q;
    assign o_Rsp_Valid   = rsp_valid_q;
    assign o_Rsp_Rdata   = rsp_rdata_q;
    assign o_Rsp_Timeout = rsp_tmo_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: one instance with TIMEOUT=8, one with TIMEOUT=0,
// selected by 'sel'. Table vectors, hand sequences and random transfers.
module tb_apb_cmd_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sel;
    logic        cmd_valid, cmd_write, rsp_ready, pready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_wdata, prdata;

    logic        a_cmd_ready, a_rsp_valid, a_rsp_timeout, a_psel, a_penable, a_pwrite;
    logic [7:0]  a_rsp_rdata, a_pwdata;
    logic [31:0] a_paddr;
    logic        b_cmd_ready, b_rsp_valid, b_rsp_timeout, b_psel, b_penable, b_pwrite;
    logic [7:0]  b_rsp_rdata, b_pwdata;
    logic [31:0] b_paddr;

    apb_cmd_master #(.TIMEOUT(8)) dut_a (
        .i_Pclk(clk), .i_Reset(rst),
        .i_Cmd_Valid(cmd_valid & ~sel), .o_Cmd_Ready(a_cmd_ready),
        .i_Cmd_Write(cmd_write), .i_Cmd_Addr(cmd_addr), .i_Cmd_Wdata(cmd_wdata),
        .o_Rsp_Valid(a_rsp_valid), .i_Rsp_Ready(rsp_ready),
        .o_Rsp_Rdata(a_rsp_rdata), .o_Rsp_Timeout(a_rsp_timeout),
        .o_Paddr(a_paddr), .o_Psel(a_psel), .o_Penable(a_penable),
        .o_Pwrite(a_pwrite), .o_Pwdata(a_pwdata),
        .i_Pready(pready), .i_Prdata(prdata)
    );

    apb_cmd_master #(.TIMEOUT(0)) dut_b (
        .i_Pclk(clk), .i_Reset(rst),
        .i_Cmd_Valid(cmd_valid & sel), .o_Cmd_Ready(b_cmd_ready),
        .i_Cmd_Write(cmd_write), .i_Cmd_Addr(cmd_addr), .i_Cmd_Wdata(cmd_wdata),
        .o_Rsp_Valid(b_rsp_valid), .i_Rsp_Ready(rsp_ready),
        .o_Rsp_Rdata(b_rsp_rdata), .o_Rsp_Timeout(b_rsp_timeout),
        .o_Paddr(b_paddr), .o_Psel(b_psel), .o_Penable(b_penable),
        .o_Pwrite(b_pwrite), .o_Pwdata(b_pwdata),
        .i_Pready(pready), .i_Prdata(prdata)
    );

    wire        cmd_ready   = sel ? b_cmd_ready   : a_cmd_ready;
    wire        rsp_valid   = sel ? b_rsp_valid   : a_rsp_valid;
    wire        rsp_timeout = sel ? b_rsp_timeout : a_rsp_timeout;
    wire [7:0]  rsp_rdata   = sel ? b_rsp_rdata   : a_rsp_rdata;
    wire        psel        = sel ? b_psel        : a_psel;
    wire        penable     = sel ? b_penable     : a_penable;
    wire        pwrite      = sel ? b_pwrite      : a_pwrite;
    wire [7:0]  pwdata      = sel ? b_pwdata      : a_pwdata;
    wire [31:0] paddr       = sel ? b_paddr       : a_paddr;

    typedef struct {
        bit          sel;
        bit          write;
        logic [31:0] addr;
        logic [7:0]  wdata;
        int          dly;       // ACCESS cycles with Pready low before it rises; -1 = never
        logic [7:0]  prdata;
        int          hold;      // cycles Rsp_Ready stays low after Rsp_Valid
        logic [7:0]  exp_rdata;
        bit          exp_tmo;
        int          exp_acc;   // expected number of ACCESS cycles
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: how long ACCESS lasts and what comes back.
    function automatic void model(input int to, input int d, input bit wr, input logic [7:0] prd,
                                  output int acc, output bit tmo, output logic [7:0] rd);
        if (to != 0 && (d < 0 || d >= to)) begin
            acc = to;
            tmo = 1'b1;
        end else begin
            acc = d + 1;
            tmo = 1'b0;
        end
        rd = (tmo || wr) ? 8'h00 : prd;
    endfunction

    task automatic xfer(input vec_t v);
        int k, acc, psel_n, bound;
        bit got, stable;
        logic [7:0] exp_pw;
        exp_pw = v.write ? v.wdata : 8'h00;
        bound  = v.exp_acc + 50;
        sel = v.sel;
        #1;
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
        pready = 1'($urandom_range(0, 1)); prdata = 8'($urandom);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_write = ~v.write; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata;
        chk("setup_psel", psel, 1);
        chk("setup_penable", penable, 0);
        chk("setup_paddr", paddr, v.addr);
        chk("setup_pwrite", pwrite, v.write);
        chk("setup_pwdata", pwdata, exp_pw);
        chk("setup_cmd_ready", cmd_ready, 0);
        pready = 1'($urandom_range(0, 1)); prdata = 8'($urandom);
        k = 0; acc = 0; psel_n = 1; got = 1'b0; stable = 1'b1;
        while (!got && k < bound) begin
            @(posedge clk); #1;
            k++;
            if (rsp_valid) begin
                got = 1'b1;
                chk("rsp_psel_low", psel, 0);
                chk("rsp_penable_low", penable, 0);
            end else begin
                if (psel) psel_n++;
                if (psel && (paddr !== v.addr || pwrite !== v.write || pwdata !== exp_pw)) stable = 1'b0;
                if (!(psel && penable)) stable = 1'b0;
                if (penable) acc++;
                pready = (v.dly >= 0 && acc > v.dly);
                prdata = pready ? v.prdata : 8'($urandom);
            end
        end
        chk("rsp_arrived", got, 1);
        chk("rsp_latency", k, v.exp_acc + 1);
        chk("access_cycles", acc, v.exp_acc);
        chk("psel_cycles", psel_n, v.exp_acc + 1);
        chk("apb_stable", stable, 1);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_timeout", rsp_timeout, v.exp_tmo);
        pready = 1'($urandom_range(0, 1)); prdata = 8'($urandom);
        for (int h = 0; h < v.hold; h++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1; cmd_write = 1'($urandom_range(0, 1)); cmd_addr = $urandom;
            @(posedge clk); #1;
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_rdata", rsp_rdata, v.exp_rdata);
            chk("hold_rsp_timeout", rsp_timeout, v.exp_tmo);
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_no_accept", psel, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("done_rsp_valid", rsp_valid, 0);
        chk("done_cmd_ready", cmd_ready, 1);
        chk("done_psel", psel, 0);
        chk("done_rdata_kept", rsp_rdata, v.exp_rdata);
        chk("done_tmo_kept", rsp_timeout, v.exp_tmo);
    endtask

    vec_t vecs[10];
    vec_t v;

    initial begin
        vecs[0] = '{0, 1, 32'h0000_0004, 8'hA5, 0,     8'h00, 0, 8'h00, 0, 1};
        vecs[1] = '{0, 0, 32'h0000_0008, 8'h00, 5,     8'h3C, 0, 8'h3C, 0, 6};
        vecs[2] = '{0, 0, 32'h0000_000C, 8'h00, -1,    8'h11, 1, 8'h00, 1, 8};
        vecs[3] = '{0, 0, 32'h0000_000C, 8'h00, 7,     8'h5A, 0, 8'h5A, 0, 8};
        vecs[4] = '{0, 0, 32'h0000_0010, 8'h00, 8,     8'h77, 0, 8'h00, 1, 8};
        vecs[5] = '{0, 1, 32'h0000_0014, 8'hC3, -1,    8'hFF, 2, 8'h00, 1, 8};
        vecs[6] = '{0, 1, 32'h0000_0018, 8'h5E, 2,     8'hEE, 4, 8'h00, 0, 3};
        vecs[7] = '{0, 0, 32'hFFFF_FFFC, 8'h00, 3,     8'h81, 4, 8'h81, 0, 4};
        vecs[8] = '{1, 0, 32'h0000_0020, 8'h00, 20,    8'h99, 1, 8'h99, 0, 21};
        vecs[9] = '{1, 1, 32'h0000_0024, 8'h42, 70000, 8'h00, 0, 8'h00, 0, 70001};

        rst = 1'b1; sel = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; pready = 1'b0; prdata = '0;

        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", cmd_ready, 1);
        @(posedge clk); #1;

        foreach (vecs[i]) xfer(vecs[i]);

        // Reset held three cycles in the middle of ACCESS aborts the transfer.
        sel = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0030; cmd_wdata = 8'h6D; pready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_in_access", penable, 1);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("midrst_psel", psel, 0);
            chk("midrst_penable", penable, 0);
            chk("midrst_rsp_valid", rsp_valid, 0);
            chk("midrst_cmd_ready", cmd_ready, 0);
        end
        rst = 1'b0;
        #1;
        chk("midrst_release_ready", cmd_ready, 1);
        chk("midrst_paddr", paddr, 0);
        chk("midrst_pwdata", pwdata, 0);
        @(posedge clk); #1;
        chk("midrst_no_rsp", rsp_valid, 0);
        chk("midrst_idle", psel, 0);

        // Random transfers checked against the transaction-level model.
        for (int i = 0; i < 40; i++) begin
            v.sel    = 1'($urandom_range(0, 1));
            v.write  = 1'($urandom_range(0, 1));
            v.addr   = $urandom;
            v.wdata  = 8'($urandom);
            v.dly    = int'($urandom_range(0, 12));
            if (!v.sel && $urandom_range(0, 3) == 0) v.dly = -1;
            v.prdata = 8'($urandom);
            v.hold   = int'($urandom_range(0, 3));
            model(v.sel ? 0 : 8, v.dly, v.write, v.prdata, v.exp_acc, v.exp_tmo, v.exp_rdata);
            xfer(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
